// File: rtl/pc_stack_unit.sv
// ----------------------------------------------------------------------------
// pc_stack_unit
//
// Program-counter unit for a core's instruction fetch stage. It runs one
// operation per cycle: increment, absolute jump, signed relative branch, and
// call/return through a bounded return-address stack. It also has halt/resume
// control and sticky fault reporting when the stack is misused.
//
// Ports
//   clk         in   clock; all state changes on the rising edge
//   reset       in   synchronous, active-high
//   stall       in   freeze; the op is ignored and all state is held
//   op          in   operation code (NOP/INC/JUMP/BREL/CALL/RET/HALT/rsvd)
//   target      in   absolute address for JUMP and CALL
//   offset      in   two's-complement offset for BREL
//   resume      in   leave the halted state
//   pc          out  current program counter (registered)
//   depth       out  number of valid stack entries
//   stack_full  out  depth == STACK_DEPTH
//   stack_empty out  depth == 0
//   halted      out  unit is halted
//   fault       out  unit is in the absorbing fault state
//   fault_code  out  01 overflow, 10 underflow, 00 none
// ----------------------------------------------------------------------------
module pc_stack_unit #(
    parameter int unsigned        ADDR_W      = 16,
    parameter int unsigned        OFF_W       = 8,
    parameter int unsigned        STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0]  RESET_ADDR  = '0,
    localparam int unsigned       DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic [2:0]         op,
    input  logic [ADDR_W-1:0]  target,
    input  logic [OFF_W-1:0]   offset,
    input  logic               resume,
    output logic [ADDR_W-1:0]  pc,
    output logic [DEPTH_W-1:0] depth,
    output logic               stack_full,
    output logic               stack_empty,
    output logic               halted,
    output logic               fault,
    output logic [1:0]         fault_code
);

    typedef enum logic [1:0] {StRun, StHalted, StFault} state_e;

    localparam logic [2:0] OpNop  = 3'b000;
    localparam logic [2:0] OpInc  = 3'b001;
    localparam logic [2:0] OpJump = 3'b010;
    localparam logic [2:0] OpBrel = 3'b011;
    localparam logic [2:0] OpCall = 3'b100;
    localparam logic [2:0] OpRet  = 3'b101;
    localparam logic [2:0] OpHalt = 3'b110;

    localparam logic [1:0] FaultNone  = 2'b00;
    localparam logic [1:0] FaultOver  = 2'b01;
    localparam logic [1:0] FaultUnder = 2'b10;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [1:0]         fault_code_q, fault_code_d;

    // Stack contents are not reset; depth_q alone says which entries are valid.
    logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];

    logic               push_en;
    logic [ADDR_W-1:0]  push_addr;
    logic [ADDR_W-1:0]  top_entry;
    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  off_ext;
    logic               full, empty;

    assign pc_inc  = pc_q + ADDR_W'(1);
    // A size cast of a signed value sign-extends, and stays valid for OFF_W == ADDR_W.
    assign off_ext = ADDR_W'($signed(offset));
    assign full    = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign empty   = (depth_q == '0);

    // Entry depth-1 is the top of stack; a loop mux avoids sizing an index to DEPTH_W.
    always_comb begin
        top_entry = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (depth_q == DEPTH_W'(i + 1)) begin
                top_entry = stack_q[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        depth_d      = depth_q;
        fault_code_d = fault_code_q;
        push_en      = 1'b0;
        push_addr    = pc_inc;

        unique case (state_q)
            StHalted: begin
                // The op on the resume cycle is dropped; RUN starts on the next edge.
                if (resume) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!stall) begin
                    unique case (op)
                        OpInc:  pc_d = pc_inc;
                        OpJump: pc_d = target;
                        OpBrel: pc_d = pc_q + off_ext;
                        OpCall: begin
                            if (full) begin
                                state_d      = StFault;
                                fault_code_d = FaultOver;
                            end else begin
                                push_en = 1'b1;
                                pc_d    = target;
                                depth_d = depth_q + DEPTH_W'(1);
                            end
                        end
                        OpRet: begin
                            if (empty) begin
                                state_d      = StFault;
                                fault_code_d = FaultUnder;
                            end else begin
                                pc_d    = top_entry;
                                depth_d = depth_q - DEPTH_W'(1);
                            end
                        end
                        OpHalt: state_d = StHalted;
                        // NOP and the reserved code both hold.
                        default: ;
                    endcase
                end
            end
            default: ; // StFault is absorbing; only reset leaves it
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StRun;
            pc_q         <= RESET_ADDR;
            depth_q      <= '0;
            fault_code_q <= FaultNone;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            depth_q      <= depth_d;
            fault_code_q <= fault_code_d;
        end
    end

    // Push writes entry[depth]; reset has priority so a CALL under reset is dropped.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (!reset && push_en && (depth_q == DEPTH_W'(i))) begin
                stack_q[i] <= push_addr;
            end
        end
    end

    assign pc          = pc_q;
    assign depth       = depth_q;
    assign stack_full  = full;
    assign stack_empty = empty;
    assign halted      = (state_q == StHalted);
    assign fault       = (state_q == StFault);
    assign fault_code  = fault_code_q;

    // Unused so far, kept for readability of the decode table above.
    logic unused_nop;
    assign unused_nop = ^OpNop;

endmodule

// File: tb/tb_pc_stack_unit.sv
module tb_pc_stack_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [2:0]  op;
    logic [15:0] target;
    logic [7:0]  offset;
    logic        resume;

    logic [15:0] pc;
    logic [2:0]  depth;
    logic        stack_full, stack_empty, halted, fault;
    logic [1:0]  fault_code;

    logic [15:0] w_pc;
    logic [2:0]  w_depth;
    logic        w_full, w_empty, w_halted, w_fault;
    logic [1:0]  w_fault_code;

    int n_checks = 0;
    int n_fail   = 0;

    pc_stack_unit #(
        .ADDR_W(16), .OFF_W(8), .STACK_DEPTH(4), .RESET_ADDR(16'h0000)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .op(op), .target(target),
        .offset(offset), .resume(resume), .pc(pc), .depth(depth),
        .stack_full(stack_full), .stack_empty(stack_empty), .halted(halted),
        .fault(fault), .fault_code(fault_code)
    );

    // Second instance only for the reset-address wrap check.
    pc_stack_unit #(
        .ADDR_W(16), .OFF_W(8), .STACK_DEPTH(4), .RESET_ADDR(16'hFFFE)
    ) dut_wrap (
        .clk(clk), .reset(reset), .stall(stall), .op(op), .target(target),
        .offset(offset), .resume(resume), .pc(w_pc), .depth(w_depth),
        .stack_full(w_full), .stack_empty(w_empty), .halted(w_halted),
        .fault(w_fault), .fault_code(w_fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pc as a 16-bit value, stack as a queue, state as a small int.
    localparam int MRun = 0, MHalt = 1, MFault = 2;
    logic [15:0] m_pc;
    logic [15:0] m_stack[$];
    int          m_state;
    logic [1:0]  m_code;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic s, input logic [2:0] o,
                              input logic [15:0] t, input logic [7:0] off,
                              input logic res);
        if (r) begin
            m_pc = 16'h0000;
            m_stack.delete();
            m_state = MRun;
            m_code = 2'b00;
        end else if (m_state == MHalt) begin
            if (res) m_state = MRun;
        end else if (m_state == MRun && !s) begin
            case (o)
                3'd1: m_pc = m_pc + 16'd1;
                3'd2: m_pc = t;
                3'd3: m_pc = m_pc + {{8{off[7]}}, off};
                3'd4: begin
                    if (m_stack.size() == 4) begin
                        m_state = MFault;
                        m_code = 2'b01;
                    end else begin
                        m_stack.push_back(m_pc + 16'd1);
                        m_pc = t;
                    end
                end
                3'd5: begin
                    if (m_stack.size() == 0) begin
                        m_state = MFault;
                        m_code = 2'b10;
                    end else begin
                        m_pc = m_stack.pop_back();
                    end
                end
                3'd6: m_state = MHalt;
                default: ;
            endcase
        end
    endtask

    task automatic check_all();
        check_eq("pc", 32'(pc), 32'(m_pc));
        check_eq("depth", 32'(depth), 32'(m_stack.size()));
        check_eq("stack_full", 32'(stack_full), 32'(m_stack.size() == 4));
        check_eq("stack_empty", 32'(stack_empty), 32'(m_stack.size() == 0));
        check_eq("halted", 32'(halted), 32'(m_state == MHalt));
        check_eq("fault", 32'(fault), 32'(m_state == MFault));
        check_eq("fault_code", 32'(fault_code), 32'(m_code));
    endtask

    // Apply one cycle of inputs, advance the model, compare 1 time unit after the edge.
    task automatic step(input logic r, input logic s, input logic [2:0] o,
                        input logic [15:0] t, input logic [7:0] off, input logic res);
        reset = r; stall = s; op = o; target = t; offset = off; resume = res;
        @(posedge clk);
        model_step(r, s, o, t, off, res);
        #1;
        check_all();
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; op = 3'd0; target = '0; offset = '0; resume = 1'b0;
        m_pc = '0; m_state = MRun; m_code = 2'b00;

        // Reset then INC x3, with the wrap instance alongside.
        step(1, 0, 3'd0, 16'h0, 8'h0, 0);
        check_eq("rst_pc", 32'(pc), 32'h0000);
        check_eq("wrap_rst_pc", 32'(w_pc), 32'hFFFE);
        step(0, 0, 3'd1, 16'h0, 8'h0, 0);
        check_eq("inc1", 32'(pc), 32'h0001);
        check_eq("wrap_inc1", 32'(w_pc), 32'hFFFF);
        step(0, 0, 3'd1, 16'h0, 8'h0, 0);
        check_eq("inc2", 32'(pc), 32'h0002);
        check_eq("wrap_inc2", 32'(w_pc), 32'h0000);
        step(0, 0, 3'd1, 16'h0, 8'h0, 0);
        check_eq("inc3", 32'(pc), 32'h0003);
        check_eq("wrap_inc3", 32'(w_pc), 32'h0001);

        // Relative branches and jump.
        step(0, 0, 3'd2, 16'h0010, 8'h0, 0);
        step(0, 0, 3'd3, 16'h0, 8'hFE, 0);
        check_eq("brel_m2", 32'(pc), 32'h000E);
        step(0, 0, 3'd2, 16'h0001, 8'h0, 0);
        step(0, 0, 3'd3, 16'h0, 8'h80, 0);
        check_eq("brel_m128", 32'(pc), 32'hFF81);
        step(0, 0, 3'd2, 16'h1234, 8'h0, 0);
        check_eq("jump", 32'(pc), 32'h1234);

        // Nested call/return.
        step(0, 0, 3'd2, 16'h0100, 8'h0, 0);
        step(0, 0, 3'd4, 16'h0200, 8'h0, 0);
        check_eq("call1_pc", 32'(pc), 32'h0200);
        check_eq("call1_depth", 32'(depth), 32'd1);
        step(0, 0, 3'd4, 16'h0300, 8'h0, 0);
        check_eq("call2_pc", 32'(pc), 32'h0300);
        check_eq("call2_depth", 32'(depth), 32'd2);
        step(0, 0, 3'd5, 16'h0, 8'h0, 0);
        check_eq("ret1_pc", 32'(pc), 32'h0201);
        check_eq("ret1_depth", 32'(depth), 32'd1);
        step(0, 0, 3'd5, 16'h0, 8'h0, 0);
        check_eq("ret2_pc", 32'(pc), 32'h0101);
        check_eq("ret2_empty", 32'(stack_empty), 32'd1);

        // Overflow.
        for (int i = 0; i < 4; i++) step(0, 0, 3'd4, 16'(16'h0A00 + i), 8'h0, 0);
        check_eq("ovf_full", 32'(stack_full), 32'd1);
        step(0, 0, 3'd4, 16'h0B00, 8'h0, 0);
        check_eq("ovf_pc", 32'(pc), 32'h0A03);
        check_eq("ovf_fault", 32'(fault), 32'd1);
        check_eq("ovf_code", 32'(fault_code), 32'd1);
        step(0, 0, 3'd5, 16'h0, 8'h0, 1);
        check_eq("ovf_absorb_pc", 32'(pc), 32'h0A03);
        check_eq("ovf_absorb_depth", 32'(depth), 32'd4);
        step(1, 0, 3'd4, 16'h0, 8'h0, 1);
        check_eq("ovf_rst_pc", 32'(pc), 32'h0000);
        check_eq("ovf_rst_fault", 32'(fault), 32'd0);

        // Underflow from reset.
        step(0, 0, 3'd5, 16'h0, 8'h0, 0);
        check_eq("unf_code", 32'(fault_code), 32'd2);
        check_eq("unf_pc", 32'(pc), 32'h0000);
        step(1, 0, 3'd0, 16'h0, 8'h0, 0);

        // Halt / resume.
        step(0, 0, 3'd2, 16'h0040, 8'h0, 0);
        step(0, 0, 3'd6, 16'h0, 8'h0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 3'd1, 16'h0, 8'h0, 0);
        check_eq("halt_pc", 32'(pc), 32'h0040);
        check_eq("halt_flag", 32'(halted), 32'd1);
        step(0, 0, 3'd1, 16'h0, 8'h0, 1);
        check_eq("resume_pc", 32'(pc), 32'h0040);
        check_eq("resume_run", 32'(halted), 32'd0);
        step(0, 0, 3'd1, 16'h0, 8'h0, 0);
        check_eq("post_resume_inc", 32'(pc), 32'h0041);

        // Stalled CALL.
        for (int i = 0; i < 3; i++) step(0, 1, 3'd4, 16'h0500, 8'h0, 0);
        check_eq("stall_pc", 32'(pc), 32'h0041);
        check_eq("stall_depth", 32'(depth), 32'd0);
        step(0, 0, 3'd4, 16'h0500, 8'h0, 0);
        check_eq("unstall_pc", 32'(pc), 32'h0500);
        check_eq("unstall_depth", 32'(depth), 32'd1);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0),
                 3'($urandom_range(0, 7)), 16'($urandom), 8'($urandom),
                 ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
